// File: rtl/riscv_v_reduct_seq.sv
// Multi-chunk bitwise reduction sequencer (vredand/vredor/vredxor): accumulate chunks, fold to SEW.
// Define RISCV_V_REDUCT_SEQ_INIT_EN to add the start_init_i scalar operand and the INIT state.
module riscv_v_reduct_seq #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned MAX_CHUNKS = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_valid_i,
    output logic                          start_ready_o,
    input  logic [1:0]                    start_op_i,
    input  logic [1:0]                    start_osize_i,
    input  logic [$clog2(MAX_CHUNKS):0]   start_num_chunks_i,
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
    input  logic [63:0]                   start_init_i,
`endif
    input  logic                          chunk_valid_i,
    output logic                          chunk_ready_o,
    input  logic [DATA_BYTES*8-1:0]       chunk_data_i,
    input  logic [DATA_BYTES-1:0]         chunk_byte_valid_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [63:0]                   result_data_o,
    output logic                          busy_o
);

    localparam int unsigned DW       = DATA_BYTES * 8;
    localparam int unsigned CW       = $clog2(MAX_CHUNKS) + 1;
    localparam int unsigned LogBytes = $clog2(DATA_BYTES);
    localparam int unsigned LvlW     = $clog2(LogBytes + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StFold,
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
        StInit,
`endif
        StDone
    } state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [1:0]       osize_q;
    logic [CW-1:0]    num_q;
    logic [CW-1:0]    cnt_q;
    logic [LvlW-1:0]  lvl_q;      // log2 of the active accumulator width in bytes
    logic [DW-1:0]    acc_q;
    logic             res_valid_q;
    logic [63:0]      res_data_q;
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
    logic [63:0]      init_q;
    logic [DW-1:0]    init_acc;
`endif

    logic [DW-1:0]    ident;
    logic [DW-1:0]    byte_mask;
    logic [DW-1:0]    chunk_eff;
    logic [DW-1:0]    lo_mask;
    logic [DW-1:0]    fold_val;
    logic [63:0]      sew_mask;
    logic [CW-1:0]    cnt_inc;
    logic             fold_done;
    int unsigned      half_bits;

    function automatic logic [DW-1:0] red_op(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        ident = (op_q == 2'b00) ? '1 : '0;
        for (int b = 0; b < int'(DATA_BYTES); b++) begin
            byte_mask[b*8 +: 8] = {8{chunk_byte_valid_i[b]}};
        end
        chunk_eff = (chunk_data_i & byte_mask) | (ident & ~byte_mask);
        // Each fold halves the active width; upper half becomes identity so later folds ignore it.
        half_bits = 32'd4 << lvl_q;
        lo_mask   = ~({DW{1'b1}} << half_bits);
        fold_val  = (red_op(op_q, acc_q, acc_q >> half_bits) & lo_mask) | (ident & ~lo_mask);
        fold_done = (lvl_q <= LvlW'(osize_q));
        cnt_inc   = cnt_q + CW'(1);
        case (osize_q)
            2'd0:    sew_mask = 64'h0000_0000_0000_00ff;
            2'd1:    sew_mask = 64'h0000_0000_0000_ffff;
            2'd2:    sew_mask = 64'h0000_0000_ffff_ffff;
            default: sew_mask = 64'hffff_ffff_ffff_ffff;
        endcase
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
        init_acc = red_op(op_q, acc_q, DW'(init_q));
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            op_q        <= '0;
            osize_q     <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            lvl_q       <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
            init_q      <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_valid_i) begin
                        op_q    <= start_op_i;
                        osize_q <= start_osize_i;
                        num_q   <= start_num_chunks_i;
                        cnt_q   <= '0;
                        lvl_q   <= LvlW'(LogBytes);
                        acc_q   <= (start_op_i == 2'b00) ? '1 : '0;
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
                        init_q  <= start_init_i;
`endif
                        state_q <= (start_num_chunks_i != '0) ? StAccum : StFold;
                    end
                end
                StAccum: begin
                    if (chunk_valid_i) begin
                        acc_q <= red_op(op_q, acc_q, chunk_eff);
                        cnt_q <= cnt_inc;
                        if (cnt_inc == num_q) state_q <= StFold;
                    end
                end
                StFold: begin
                    if (fold_done) begin
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
                        state_q     <= StInit;
`else
                        res_valid_q <= 1'b1;
                        res_data_q  <= acc_q[63:0] & sew_mask;
                        state_q     <= StDone;
`endif
                    end else begin
                        acc_q <= fold_val;
                        lvl_q <= lvl_q - LvlW'(1);
                    end
                end
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
                StInit: begin
                    acc_q       <= (init_acc & DW'(sew_mask)) | (acc_q & ~DW'(sew_mask));
                    res_valid_q <= 1'b1;
                    res_data_q  <= init_acc[63:0] & sew_mask;
                    state_q     <= StDone;
                end
`endif
                StDone: begin
                    if (result_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_ready_o  = (state_q == StIdle);
    assign chunk_ready_o  = (state_q == StAccum);
    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = res_valid_q;
    assign result_data_o  = res_data_q;

    // Oversized chunk counts are a caller bug; the sequencer does not clamp them.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (start_valid_i && start_ready_o) |-> (start_num_chunks_i <= CW'(MAX_CHUNKS)));

endmodule

// File: tb/tb_riscv_v_reduct_seq.sv
// Randomized self-checking bench for riscv_v_reduct_seq against an element-wise reduction model.
// Honours RISCV_V_REDUCT_SEQ_INIT_EN for the scalar init operand.
module tb_riscv_v_reduct_seq;

    localparam int unsigned DB = 16;
    localparam int unsigned MC = 8;
    localparam int unsigned DW = DB * 8;
    localparam int unsigned CW = $clog2(MC) + 1;
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
    localparam int InitCyc = 1;
    localparam bit UseInit = 1'b1;
`else
    localparam int InitCyc = 0;
    localparam bit UseInit = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [1:0]    start_op;
    logic [1:0]    start_osize;
    logic [CW-1:0] start_num;
    logic [63:0]   start_init;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [DW-1:0] chunk_data;
    logic [DB-1:0] chunk_bv;
    logic          result_valid;
    logic          result_ready;
    logic [63:0]   result_data;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ch_data [MC];
    logic [DB-1:0] ch_bv   [MC];

    riscv_v_reduct_seq #(.DATA_BYTES(DB), .MAX_CHUNKS(MC)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_valid_i      (start_valid),
        .start_ready_o      (start_ready),
        .start_op_i         (start_op),
        .start_osize_i      (start_osize),
        .start_num_chunks_i (start_num),
`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
        .start_init_i       (start_init),
`endif
        .chunk_valid_i      (chunk_valid),
        .chunk_ready_o      (chunk_ready),
        .chunk_data_i       (chunk_data),
        .chunk_byte_valid_i (chunk_bv),
        .result_valid_o     (result_valid),
        .result_ready_i     (result_ready),
        .result_data_o      (result_data),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] apply(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        if (op == 2'b00) return a & b;
        if (op == 2'b01) return a | b;
        return a ^ b;
    endfunction

    // Reduce every SEW element of every chunk, invalid bytes taking the identity byte.
    function automatic logic [63:0] ref_red(input logic [1:0] op, input logic [1:0] osize,
                                            input int n, input logic [63:0] init);
        int ebytes;
        int nel;
        int idx;
        logic [63:0] m;
        logic [63:0] r;
        logic [63:0] e;
        ebytes = 1 << osize;
        nel    = DB / ebytes;
        m      = (osize == 2'd3) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << (8 * ebytes)) - 64'd1);
        r      = (op == 2'b00) ? '1 : '0;
        for (int c = 0; c < n; c++) begin
            for (int el = 0; el < nel; el++) begin
                e = '0;
                for (int b = 0; b < ebytes; b++) begin
                    idx = el * ebytes + b;
                    e[b*8 +: 8] = ch_bv[c][idx] ? ch_data[c][idx*8 +: 8]
                                                : ((op == 2'b00) ? 8'hff : 8'h00);
                end
                r = apply(op, r, e);
            end
        end
        if (UseInit) r = apply(op, r, init);
        return r & m;
    endfunction

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [1:0] osize,
                           input int n, input logic [63:0] init, input int gap_pct,
                           input int hold, input bit poke, output logic [63:0] got);
        int lat = 0;
        int gaps = 0;
        int guard = 0;
        int cr_seen = 0;
        logic [63:0] exp_res;
        exp_res = ref_red(op, osize, n, init);
        check({tag, " start_ready"}, 64'(start_ready), 64'd1);
        start_valid = 1'b1;
        start_op    = op;
        start_osize = osize;
        start_num   = CW'(n);
        start_init  = init;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct && gaps < 50) begin
                chunk_valid = 1'b0;
                tick();
                lat++;
                gaps++;
            end
            chunk_valid = 1'b1;
            chunk_data  = ch_data[i];
            chunk_bv    = ch_bv[i];
            check({tag, " chunk_ready"}, 64'(chunk_ready), 64'd1);
            tick();
            lat++;
        end
        // Junk chunks after the stream must be ignored.
        chunk_valid = 1'($urandom_range(1));
        chunk_data  = {$urandom, $urandom, $urandom, $urandom};
        chunk_bv    = '1;
        while (result_valid !== 1'b1 && guard < 40) begin
            if (chunk_ready) cr_seen++;
            tick();
            lat++;
            guard++;
        end
        chunk_valid = 1'b0;
        got = result_data;
        check({tag, " result_valid"}, 64'(result_valid), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(1 + n + (4 - int'(osize)) + gaps + InitCyc));
        check({tag, " chunk_ready_in_fold"}, 64'(cr_seen), 64'd0);
        check({tag, " data"}, result_data, exp_res);
        for (int h = 0; h < hold; h++) begin
            start_valid = poke;
            tick();
            check({tag, " hold_valid"}, 64'(result_valid), 64'd1);
            check({tag, " hold_data"}, result_data, exp_res);
            check({tag, " hold_start_ready"}, 64'(start_ready), 64'd0);
        end
        result_ready = 1'b1;
        start_valid  = poke;
        tick();
        result_ready = 1'b0;
        start_valid  = 1'b0;
        check({tag, " valid_drop"}, 64'(result_valid), 64'd0);
        check({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    logic [63:0] got;
    logic [1:0]  r_op;
    logic [1:0]  r_os;
    int          r_n;

    initial begin
        rst = 1'b1;
        start_valid = 1'b0; start_op = '0; start_osize = '0; start_num = '0; start_init = '0;
        chunk_valid = 1'b0; chunk_data = '0; chunk_bv = '0; result_ready = 1'b0;
        tick();
        tick();
        check("rst start_ready", 64'(start_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst chunk_ready", 64'(chunk_ready), 64'd0);
        check("rst result_valid", 64'(result_valid), 64'd0);
        check("rst result_data", result_data, 64'd0);
        rst = 1'b0;
        tick();

        // XOR SEW8 over bytes 0x01..0x10
        for (int b = 0; b < int'(DB); b++) ch_data[0][b*8 +: 8] = 8'(b + 1);
        ch_bv[0] = '1;
        run_txn("t1", 2'b10, 2'd0, 1, 64'd0, 0, 0, 1'b0, got);
        check("t1 const", got, 64'h10);

        // AND SEW32, second chunk fully masked
        ch_data[0] = '1;
        ch_data[0][7:0] = 8'hf0;
        ch_bv[0] = '1;
        ch_data[1] = {$urandom, $urandom, $urandom, $urandom};
        ch_bv[1] = '0;
        run_txn("t2", 2'b00, 2'd2, 2, 64'hffff_ffff_ffff_ffff, 0, 0, 1'b0, got);
        check("t2 const", got, UseInit ? 64'hffff_fff0 : 64'hffff_fff0);

        // Zero chunks returns identity
        run_txn("t3or", 2'b01, 2'd1, 0, 64'd0, 0, 0, 1'b0, got);
        check("t3or const", got, 64'h0);
        run_txn("t3and", 2'b00, 2'd0, 0, 64'hff, 0, 0, 1'b0, got);
        check("t3and const", got, 64'hff);

        // Backpressure in DONE with an ignored start pulse
        for (int c = 0; c < 3; c++) begin
            ch_data[c] = {$urandom, $urandom, $urandom, $urandom};
            ch_bv[c] = 16'($urandom);
        end
        run_txn("t4", 2'b01, 2'd1, 3, 64'h1234, 0, 5, 1'b1, got);

        // Reset mid-accumulation
        start_valid = 1'b1; start_op = 2'b10; start_osize = 2'd0; start_num = CW'(3);
        tick();
        start_valid = 1'b0;
        chunk_valid = 1'b1; chunk_data = ch_data[0]; chunk_bv = '1;
        tick();
        chunk_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 busy", 64'(busy), 64'd0);
        check("t5 start_ready", 64'(start_ready), 64'd1);
        check("t5 chunk_ready", 64'(chunk_ready), 64'd0);
        check("t5 result_valid", 64'(result_valid), 64'd0);
        check("t5 result_data", result_data, 64'd0);
        chunk_valid = 1'b1;
        tick();
        chunk_valid = 1'b0;
        check("t5 ignored_chunk", 64'(busy), 64'd0);

`ifdef RISCV_V_REDUCT_SEQ_INIT_EN
        for (int b = 0; b < int'(DB); b++) ch_data[0][b*8 +: 8] = 8'(b + 1);
        ch_bv[0] = '1;
        run_txn("t6", 2'b10, 2'd0, 1, 64'hab, 0, 0, 1'b0, got);
        check("t6 const", got, 64'hbb);
`endif

        for (int t = 0; t < 40; t++) begin
            r_op = 2'($urandom_range(3));
            r_os = 2'($urandom_range(3));
            r_n  = int'($urandom_range(MC));
            for (int c = 0; c < int'(MC); c++) begin
                ch_data[c] = {$urandom, $urandom, $urandom, $urandom};
                if (r_op == 2'b00) ch_data[c] = ~(ch_data[c] & {$urandom, $urandom, $urandom, $urandom}
                                                  & {$urandom, $urandom, $urandom, $urandom});
                ch_bv[c] = ($urandom_range(1) == 1) ? '1 : 16'($urandom);
            end
            run_txn($sformatf("rnd%0d", t), r_op, r_os, r_n, {$urandom, $urandom},
                    int'($urandom_range(40)), int'($urandom_range(3)), 1'($urandom_range(1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
